ultrasound_echo_tof: RTL and testbench
======================================

ULTRASOUND_ECHO_TOF -- requirements
Module: ultrasound_echo_tof

Interface
REQ-001 SHALL have parameter BLANK_CYC, default 2500, meaning post-launch blanking length in clk_50M cycles (50 us, masks transducer ringing).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1_500_000, meaning maximum listen span in cycles (30 ms); legal only if TIMEOUT_CYC > BLANK_CYC.
REQ-003 SHALL have parameter FILT_LEN, default 4, meaning consecutive high samples that qualify an echo; legal range 1..15.
REQ-004 SHALL have port clk_50M  input  1  system clock, 50 MHz.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port launch_start  input  1  single-cycle pulse, synchronous to clk_50M, marking the first cycle of the 4-channel excitation burst.
REQ-007 SHALL have port echo_in  input  1  receiver comparator output, asynchronous to clk_50M.
REQ-008 SHALL have port busy  output  1  high while a measurement is in progress (BLANK or LISTEN).
REQ-009 SHALL have port tof_value  output  21  measured time of flight in cycles; holds until the next result.
REQ-010 SHALL have port tof_timeout  output  1  set when the last result was a timeout; holds until the next result.
REQ-011 SHALL have port tof_valid  output  1  one-cycle pulse when tof_value/tof_timeout are updated.

Function
REQ-012 SHALL pass echo_in through a 2-flop synchronizer; echo_s is the second-flop output, and all echo decisions use echo_s only.
REQ-013 SHALL implement an FSM with states IDLE, BLANK, LISTEN, DONE.
REQ-014 SHALL, in any state, on an edge that samples launch_start=1, clear tof_cnt to 0, clear the filter run, clear armed, and enter BLANK; an in-flight measurement is then aborted without tof_valid.
REQ-015 SHALL increment the 21-bit tof_cnt by 1 on every edge in BLANK and LISTEN; tof_cnt equals the number of edges since the edge that sampled launch_start.
REQ-016 SHALL, in BLANK, ignore echo_s, and enter LISTEN on the edge where tof_cnt becomes BLANK_CYC.
REQ-017 SHALL, in LISTEN, set armed on the first edge that samples echo_s=0; a high level persisting from blanking never qualifies.
REQ-018 SHALL, in LISTEN with armed=1, do the following on each edge sampling echo_s=1: increment run_len, saturating at FILT_LEN; and when run_len was 0, capture the current tof_cnt into cand.
REQ-019 SHALL clear run_len on any LISTEN edge sampling echo_s=0 and discard cand (glitch rejection).
REQ-020 SHALL, on the edge where run_len reaches FILT_LEN, load tof_value<=cand and tof_timeout<=0, and enter DONE.
REQ-021 SHALL, on the edge where tof_cnt reaches TIMEOUT_CYC in LISTEN without qualification, load tof_value<=TIMEOUT_CYC and tof_timeout<=1, and enter DONE; qualification on that same edge takes priority over timeout.
REQ-022 SHALL assert tof_valid for exactly the single cycle spent in DONE, then return to IDLE; launch_start during DONE follows REQ-014, and tof_valid still pulses for the completed result.
REQ-023 SHALL drive busy=1 exactly when the state is BLANK or LISTEN.
REQ-024 SHALL ignore echo_s entirely in IDLE and DONE.
REQ-025 SHALL NOT compensate for synchronizer latency; the reported value includes the 2-cycle synchronizer delay.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state=IDLE, tof_cnt=0, run_len=0, armed=0, cand=0, synchronizer flops=0, busy=0, tof_valid=0, tof_value=0, tof_timeout=0.
REQ-027 SHALL, on reset asserted mid-measurement, discard the measurement, produce no tof_valid after release, and remain in IDLE until the next launch_start.

Verification
REQ-028 SHALL cover the nominal echo: launch_start at T0; echo_in held high so echo_s first samples high at tof_cnt=30000 for 10 cycles -> one tof_valid, tof_value=30000, tof_timeout=0.
REQ-029 SHALL cover glitch rejection: echo_s high for 3 cycles at tof_cnt 10000, then low, then high for 4 cycles starting at tof_cnt 12000 -> tof_value=12000.
REQ-030 SHALL cover ringing through blanking: echo_in high from launch through tof_cnt 2600, then low, then high at 5000 -> tof_value=5000 and no detection at 2500.
REQ-031 SHALL cover timeout: no echo -> tof_valid on the edge after tof_cnt=1_500_000, tof_value=1_500_000, tof_timeout=1, busy=0 afterwards.
REQ-032 SHALL cover relaunch mid-LISTEN: a second launch_start at tof_cnt 8000 -> no tof_valid for the first launch; an echo at 20000 cycles after the second launch gives tof_value=20000.
REQ-033 SHALL cover reset mid-BLANK: rst_n low for 3 cycles at tof_cnt 1000 -> all outputs 0 and busy=0, with no tof_valid before the next launch.

Source files
------------

// File: rtl/ultrasound_echo_tof.sv
// Ultrasonic echo time-of-flight: blanks transducer ringing after launch, then
// reports the cycle count of the first filtered echo, or a timeout.
module ultrasound_echo_tof #(
    parameter int unsigned BLANK_CYC   = 2500,
    parameter int unsigned TIMEOUT_CYC = 1_500_000,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        launch_start,
    input  logic        echo_in,
    output logic        busy,
    output logic [20:0] tof_value,
    output logic        tof_timeout,
    output logic        tof_valid
);

    localparam int CW = 21;
    localparam logic [CW-1:0] BLANK_END   = CW'(BLANK_CYC);
    localparam logic [CW-1:0] TIMEOUT_END = CW'(TIMEOUT_CYC);
    localparam logic [3:0]    RUN_LAST    = 4'(FILT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_LISTEN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic            echo_meta_q, echo_s_q;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [3:0]      run_q, run_d;
    logic            armed_q, armed_d;
    logic [CW-1:0]   cand_q, cand_d;
    logic [CW-1:0]   tof_value_q, tof_value_d;
    logic            tof_timeout_q, tof_timeout_d;
    logic            qualify;

    assign cnt_inc = cnt_q + 1'b1;

    // NOTE: every register, including the synchronizer pair, takes the async
    // reset; sequential state uses only non-blocking assignments.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            echo_meta_q   <= 1'b0;
            echo_s_q      <= 1'b0;
            cnt_q         <= '0;
            run_q         <= '0;
            armed_q       <= 1'b0;
            cand_q        <= '0;
            tof_value_q   <= '0;
            tof_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            echo_meta_q   <= echo_in;
            echo_s_q      <= echo_meta_q;
            cnt_q         <= cnt_d;
            run_q         <= run_d;
            armed_q       <= armed_d;
            cand_q        <= cand_d;
            tof_value_q   <= tof_value_d;
            tof_timeout_q <= tof_timeout_d;
        end
    end

    // NOTE: every next-state signal is defaulted first so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        run_d         = run_q;
        armed_d       = armed_q;
        cand_d        = cand_q;
        tof_value_d   = tof_value_q;
        tof_timeout_d = tof_timeout_q;
        qualify       = 1'b0;

        if (launch_start) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            run_d   = '0;
            armed_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_BLANK: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == BLANK_END) state_d = S_LISTEN;
                end
                S_LISTEN: begin
                    cnt_d = cnt_inc;
                    if (!echo_s_q) begin
                        // A low sample arms detection and rejects any partial run.
                        armed_d = 1'b1;
                        run_d   = '0;
                        cand_d  = '0;
                    end else if (armed_q) begin
                        if (run_q == '0) cand_d = cnt_q;
                        if (run_q != RUN_LAST + 1'b1) run_d = run_q + 1'b1;
                        qualify = (run_q == RUN_LAST);
                    end
                    if (qualify) begin
                        tof_value_d   = cand_d;
                        tof_timeout_d = 1'b0;
                        state_d       = S_DONE;
                    end else if (cnt_inc == TIMEOUT_END) begin
                        tof_value_d   = TIMEOUT_END;
                        tof_timeout_d = 1'b1;
                        state_d       = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy        = (state_q == S_BLANK) || (state_q == S_LISTEN);
    assign tof_valid   = (state_q == S_DONE);
    assign tof_value   = tof_value_q;
    assign tof_timeout = tof_timeout_q;

endmodule

// File: tb/tb_ultrasound_echo_tof.sv
// Scoreboard bench for ultrasound_echo_tof with shortened blanking/timeout so
// every scenario fits in a short run.
module tb_ultrasound_echo_tof;

    localparam int BLANK = 250;
    localparam int TMO   = 6000;
    localparam int FILT  = 4;

    logic        clk_50M = 1'b0;
    logic        rst_n = 1'b0;
    logic        launch_start = 1'b0;
    logic        echo_in = 1'b0;
    logic        busy;
    logic [20:0] tof_value;
    logic        tof_timeout;
    logic        tof_valid;

    ultrasound_echo_tof #(
        .BLANK_CYC  (BLANK),
        .TIMEOUT_CYC(TMO),
        .FILT_LEN   (FILT)
    ) dut (
        .clk_50M     (clk_50M),
        .rst_n       (rst_n),
        .launch_start(launch_start),
        .echo_in     (echo_in),
        .busy        (busy),
        .tof_value   (tof_value),
        .tof_timeout (tof_timeout),
        .tof_valid   (tof_valid)
    );

    always #10 clk_50M = ~clk_50M;

    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    typedef struct {
        logic timeout;
        int   value;
        int   cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   t0 = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Results are compared in order as the DUT pulses tof_valid.
    always @(negedge clk_50M) begin
        if (tof_valid) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("tof_value", int'(tof_value), mon_e.value);
                check("tof_timeout", int'(tof_timeout), int'(mon_e.timeout));
                check("valid_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic expect_result(input logic to, input int val, input int at);
        sb_q.push_back(exp_t'{timeout: to, value: val, cyc: at});
    endtask

    // Called at a falling edge; the next rising edge samples launch_start,
    // after which tof_cnt equals cyc - t0 at each falling edge.
    task automatic launch();
        launch_start = 1'b1;
        @(negedge clk_50M);
        launch_start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_until(input int k);
        while (cyc - t0 < k) @(negedge clk_50M);
    endtask

    // Makes echo_s sample high for 'len' edges starting at tof_cnt = first.
    task automatic echo_pulse(input int first, input int len);
        wait_until(first - 2);
        echo_in = 1'b1;
        wait_until(first - 2 + len);
        echo_in = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk_50M);
        check("drain", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !tof_valid; i++) @(negedge clk_50M);
        check("valid_seen", int'(tof_valid), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk_50M);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(tof_valid), 0);
        check("rst_value", int'(tof_value), 0);
        check("rst_timeout", int'(tof_timeout), 0);
        rst_n = 1'b1;
        @(negedge clk_50M);

        // Nominal echo.
        launch();
        check("busy_blank", int'(busy), 1);
        expect_result(1'b0, 3000, t0 + 3000 + FILT);
        wait_until(BLANK + 10);
        check("busy_listen", int'(busy), 1);
        echo_pulse(3000, 10);
        wait_drain(200);
        repeat (5) @(negedge clk_50M);
        check("hold_value", int'(tof_value), 3000);
        check("idle_busy", int'(busy), 0);
        check("idle_valid", int'(tof_valid), 0);

        // Launch landing on the DONE cycle: result still reported, new run starts.
        launch();
        expect_result(1'b0, 400, t0 + 400 + FILT);
        echo_pulse(400, FILT);
        wait_valid(50);
        launch();
        check("busy_after_done_launch", int'(busy), 1);
        expect_result(1'b0, 300, t0 + 300 + FILT);
        echo_pulse(300, 5);
        wait_drain(100);

        // Glitch one sample short of the filter, then a real echo.
        launch();
        expect_result(1'b0, 1200, t0 + 1200 + FILT);
        echo_pulse(1000, FILT - 1);
        echo_pulse(1200, FILT);
        wait_drain(100);

        // Ringing held high through the end of blanking must not qualify.
        echo_in = 1'b1;
        launch();
        expect_result(1'b0, 500, t0 + 500 + FILT);
        wait_until(259);
        echo_in = 1'b0;
        echo_pulse(500, 6);
        wait_drain(100);

        // Relaunch mid-LISTEN aborts the first measurement.
        launch();
        wait_until(800);
        check("busy_before_relaunch", int'(busy), 1);
        launch();
        expect_result(1'b0, 2000, t0 + 2000 + FILT);
        echo_pulse(2000, 5);
        wait_drain(100);

        // Reset in BLANK clears everything immediately; no result afterwards.
        launch();
        wait_until(100);
        check("busy_pre_reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(tof_valid), 0);
        check("mid_rst_value", int'(tof_value), 0);
        check("mid_rst_timeout", int'(tof_timeout), 0);
        repeat (3) @(negedge clk_50M);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_50M);
        echo_in = 1'b1;
        repeat (10) @(negedge clk_50M);
        echo_in = 1'b0;
        repeat (BLANK + 200) @(negedge clk_50M);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_value", int'(tof_value), 0);
        check("post_rst_no_result", sb_q.size(), 0);

        // No echo: timeout result.
        launch();
        expect_result(1'b1, TMO, t0 + TMO);
        wait_drain(TMO + 100);
        repeat (3) @(negedge clk_50M);
        check("tmo_busy", int'(busy), 0);
        check("tmo_hold_flag", int'(tof_timeout), 1);
        check("tmo_hold_value", int'(tof_value), TMO);

        // Qualification on the timeout edge wins over timeout.
        launch();
        expect_result(1'b0, TMO - FILT, t0 + TMO);
        echo_pulse(TMO - FILT, 6);
        wait_drain(100);
        check("prio_flag", int'(tof_timeout), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
